// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: walks a 4x4 matrix one column at a time, debounces a
// single key and emits exactly one strobe per press, tracking held/released state.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [1:0] col_sel,
  output logic       col_en_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state_o
);

  localparam int unsigned   DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB        = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, rs_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic          col_en_n_q;
  logic [1:0]    row_q, row_d;
  logic [3:0]    match_q, match_d;
  logic [3:0]    rel_q, rel_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          sample;
  logic          single;
  logic          row_match;
  logic [1:0]    row_idx;

  // Multi-key patterns are deliberately not "single", so every state treats them as none.
  assign sample    = (dwell_q == DWELL_LAST);
  assign single    = (rs_q != 4'd0) && ((rs_q & (rs_q - 4'd1)) == 4'd0);
  assign row_match = single && (row_idx == row_q);

  always_comb begin
    row_idx = 2'd0;
    case (rs_q)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    col_d   = col_q;
    row_d   = row_q;
    match_d = match_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (single) begin
            row_d = row_idx;
            if (DEBOUNCE == 1) begin
              code_d  = {row_idx, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              match_d = 4'd0;
              state_d = ST_HELD;
            end else begin
              match_d = 4'd1;
              state_d = ST_CONFIRM;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      ST_CONFIRM: begin
        if (sample) begin
          if (row_match) begin
            if (match_q + 4'd1 == DEB) begin
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              match_d = 4'd0;
              state_d = ST_HELD;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            match_d = 4'd0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_HELD: begin
        // Any key activity, even a different key, restarts the release debounce.
        if (sample) begin
          if (!single) begin
            if (rel_q + 4'd1 == DEB) begin
              rel_d   = 4'd0;
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
              state_d = ST_SCAN;
            end else begin
              rel_d = rel_q + 4'd1;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      sync1_q    <= 4'd0;
      rs_q       <= 4'd0;
      dwell_q    <= '0;
      col_q      <= 2'd0;
      col_en_n_q <= 1'b1;
      row_q      <= 2'd0;
      match_q    <= 4'd0;
      rel_q      <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= row_in;
      rs_q       <= sync1_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_en_n_q <= 1'b0;
      row_q      <= row_d;
      match_q    <= match_d;
      rel_q      <= rel_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  assign col_sel     = col_q;
  assign col_en_n    = col_en_n_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model drives rows from the active
// column, and a monitor checks every strobe against queued expected key codes.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in = 4'd0;
  logic [1:0] col_sel;
  logic       col_en_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dbg_state;

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  bit         key_down = 1'b0;
  logic [3:0] key_idx  = 4'd0;
  bit         multi_on = 1'b0;
  int         lat;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  keypad_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_sel    (col_sel),
    .col_en_n   (col_en_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .dbg_state_o(dbg_state)
  );

  // Physical keypad: a pressed key shorts its row only while its column is driven.
  always @(posedge clk) begin
    #3;
    if (col_en_n !== 1'b0) row_in = 4'b0000;
    else if (multi_on && col_sel == 2'd0) row_in = 4'b0101;
    else if (key_down && col_sel == key_idx[1:0]) row_in = 4'b0001 << key_idx[3:2];
    else row_in = 4'b0000;
  end

  // ---------------- driver / helper tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_col_enter(input logic [1:0] v, input int budget);
    logic [1:0] prev;
    int n;
    prev = col_sel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (col_sel == v && prev != v) return;
      prev = col_sel;
    end while (n < budget);
    chk_cnt++;
    $display("FAIL wait_col_enter: col_sel=%0d never entered %0d within %0d cycles", col_sel, v, budget);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col_sel"},   int'(col_sel),   0);
    check({tag, "_col_en_n"},  int'(col_en_n),  1);
    check({tag, "_key_code"},  int'(key_code),  0);
    check({tag, "_key_valid"}, int'(key_valid), 0);
    check({tag, "_key_held"},  int'(key_held),  0);
    check({tag, "_state"},     int'(dbg_state), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_strobe: got key_code %0d expected no strobe", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("strobe_code", int'(key_code), int'(mon_exp));
        check("held_with_strobe", int'(key_held), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Idle scanning: column advances every SCAN_DIV cycles, first dwell shortened by reset.
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("idle_col_sel", int'(col_sel), ((k + 1) / SCAN_DIV) % 4);
      check("idle_col_en_n", int'(col_en_n), 0);
    end

    // Press row 2 / column 1 (key 9) before column 1 comes round.
    key_idx  = 4'd9;
    key_down = 1'b1;
    exp_q.push_back(4'd9);
    wait_col_enter(2'd1, 20);
    lat = 0;
    while (key_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("press_latency", lat, DEBOUNCE * SCAN_DIV);
    check("press_col_frozen", int'(col_sel), 1);
    for (int d = 0; d < 20; d++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check("hold_col_sel", int'(col_sel), 1);
      check("hold_key_held", int'(key_held), 1);
      check("hold_state", int'(dbg_state), 2);
    end

    // Release: aligned so the very next sample is the first none sample.
    key_down = 1'b0;
    lat = 0;
    while (key_held !== 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("release_latency", lat, DEBOUNCE * SCAN_DIV);
    check("release_col_next", int'(col_sel), 2);
    check("release_state", int'(dbg_state), 0);
    check("release_code_kept", int'(key_code), 9);
    repeat (SCAN_DIV) @(negedge clk);
    check("resume_col", int'(col_sel), 3);

    // Bounce on key 3 (row 0, column 3): one matching sample, then a gap.
    for (int b = 0; b < 2; b++) begin
      wait_col_enter(2'd3, 40);
      key_idx  = 4'd3;
      key_down = 1'b1;
      repeat (SCAN_DIV) @(negedge clk);
      check("bounce_confirm_state", int'(dbg_state), 1);
      check("bounce_confirm_col", int'(col_sel), 3);
      key_down = 1'b0;
      repeat (SCAN_DIV) @(negedge clk);
      check("bounce_back_state", int'(dbg_state), 0);
      check("bounce_back_col", int'(col_sel), 0);
    end

    // Two rows on column 0 for 10 dwells: treated as nothing pressed.
    wait_col_enter(2'd3, 40);
    multi_on = 1'b1;
    for (int d = 0; d < 10; d++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check("multi_col_sel", int'(col_sel), (3 + d + 1) % 4);
      check("multi_state", int'(dbg_state), 0);
    end
    multi_on = 1'b0;

    // Reset mid-confirm on key 6 (row 1, column 2), key kept pressed.
    key_idx  = 4'd6;
    key_down = 1'b1;
    wait_col_enter(2'd2, 40);
    repeat (SCAN_DIV + 2) @(negedge clk);
    check("pre_rst_confirm", int'(dbg_state), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    exp_q.push_back(4'd6);
    lat = 0;
    while (key_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    // Columns 0,1 then reach 2 after 2*SCAN_DIV edges; then DEBOUNCE full dwells.
    check("post_rst_latency", lat, 2 * SCAN_DIV + DEBOUNCE * SCAN_DIV);
    key_down = 1'b0;
    lat = 0;
    while (key_held !== 1'b0 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("final_release", int'(key_held), 0);
    check("final_code_kept", int'(key_code), 6);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
